// File: rtl/spu_shift_pkg.sv
// Shared op/size encodings, lane geometry and the pipeline stage record
// for the SPU quadword shift/rotate pipe.
package spu_shift_pkg;

    localparam int QW_BITS    = 128;
    localparam int HALF_W     = 16;
    localparam int WORD_W     = 32;
    localparam int HALF_LANES = QW_BITS / HALF_W;
    localparam int WORD_LANES = QW_BITS / WORD_W;
    localparam int ADDR_W     = 7;
    localparam int IMM_W      = 7;

    typedef enum logic [1:0] {
        OP_SHL   = 2'd0,
        OP_ROT   = 2'd1,
        OP_ROTM  = 2'd2,
        OP_ROTMA = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ES_HALF  = 2'd0,
        ES_WORD  = 2'd1,
        ES_RSVD2 = 2'd2,
        ES_RSVD3 = 2'd3
    } esize_e;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic [ADDR_W-1:0]   addr;
        logic [QW_BITS-1:0]  data;
    } stage_t;

    function automatic logic esize_legal(input esize_e es);
        return (es == ES_HALF) || (es == ES_WORD);
    endfunction

endpackage

// File: rtl/shift_lane.sv
// One W-bit lane of shift/rotate; purely combinational.
// Counts are taken modulo 2W (shifts) or W (rotate); larger bits are ignored.
module shift_lane
    import spu_shift_pkg::*;
#(
    parameter int W = 16
) (
    input  op_e          op,
    input  logic [W-1:0] lane,
    input  logic [W-1:0] cnt,
    output logic [W-1:0] res
);

    localparam int SW = $clog2(W);

    logic [SW:0]   fwd_n;
    logic [SW:0]   rev_n;
    logic [SW-1:0] sra_n;
    logic [W-1:0]  rot;
    logic          unused_cnt_hi;

    // Only the low log2(2W) bits of the count (or of its negation) matter.
    assign fwd_n         = cnt[SW:0];
    assign rev_n         = -fwd_n;
    assign sra_n         = rev_n[SW] ? SW'(W - 1) : rev_n[SW-1:0];
    assign unused_cnt_hi = ^cnt[W-1:SW+1];

    always_comb begin
        rot = '0;
        for (int i = 0; i < W; i++) begin
            rot[i] = lane[SW'(i) - fwd_n[SW-1:0]];
        end
    end

    always_comb begin
        res = '0;
        case (op)
            OP_SHL:   res = fwd_n[SW] ? '0 : (lane << fwd_n[SW-1:0]);
            OP_ROT:   res = rot;
            OP_ROTM:  res = rev_n[SW] ? '0 : (lane >> rev_n[SW-1:0]);
            OP_ROTMA: res = $unsigned($signed(lane) >>> sra_n);
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/shift_rotate_pipe.sv
// Quadword lane shift/rotate, result computed at the sampling edge and carried
// LATENCY-1 further edges to writeback; no backpressure, issue every cycle.
module shift_rotate_pipe
    import spu_shift_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int KILL_STAGES = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [1:0]                       op,
    input  logic [1:0]                       esize,
    input  logic                             use_imm,
    input  logic [QW_BITS-1:0]               ra,
    input  logic [QW_BITS-1:0]               rb,
    input  logic [IMM_W-1:0]                 imm7,
    input  logic [ADDR_W-1:0]                rt_addr,
    input  logic                             reg_write,
    input  logic                             flush,
    output logic [QW_BITS-1:0]               rt_wb,
    output logic [ADDR_W-1:0]                rt_addr_wb,
    output logic                             reg_write_wb,
    output logic                             wb_valid,
    output logic [LATENCY-1:0]               stg_valid,
    output logic [LATENCY-1:0]               stg_reg_write,
    output logic [LATENCY-1:0][ADDR_W-1:0]   stg_addr,
    output logic                             illegal_op
);

    stage_t [LATENCY-1:0] stg;
    stage_t               stg_in;
    logic [QW_BITS-1:0]   res_half;
    logic [QW_BITS-1:0]   res_word;
    op_e                  opc;
    esize_e               es;
    logic                 legal;

    assign opc   = op_e'(op);
    assign es    = esize_e'(esize);
    assign legal = esize_legal(es);

    // Element 0 sits in the most significant bits of the quadword.
    for (genvar i = 0; i < HALF_LANES; i++) begin : g_half
        localparam int HI = QW_BITS - 1 - i * HALF_W;
        logic [HALF_W-1:0] cnt;
        assign cnt = use_imm ? {{(HALF_W-IMM_W){imm7[IMM_W-1]}}, imm7} : rb[HI -: HALF_W];
        shift_lane #(.W(HALF_W)) u_lane (
            .op   (opc),
            .lane (ra[HI -: HALF_W]),
            .cnt  (cnt),
            .res  (res_half[HI -: HALF_W])
        );
    end

    for (genvar i = 0; i < WORD_LANES; i++) begin : g_word
        localparam int HI = QW_BITS - 1 - i * WORD_W;
        logic [WORD_W-1:0] cnt;
        assign cnt = use_imm ? {{(WORD_W-IMM_W){imm7[IMM_W-1]}}, imm7} : rb[HI -: WORD_W];
        shift_lane #(.W(WORD_W)) u_lane (
            .op   (opc),
            .lane (ra[HI -: WORD_W]),
            .cnt  (cnt),
            .res  (res_word[HI -: WORD_W])
        );
    end

    always_comb begin
        stg_in = '0;
        if (in_valid && legal) begin
            stg_in.valid     = 1'b1;
            stg_in.reg_write = reg_write;
            stg_in.addr      = rt_addr;
            stg_in.data      = (es == ES_HALF) ? res_half : res_word;
        end
    end

    // Flush kills the incoming op and the KILL_STAGES youngest in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg        <= '0;
            illegal_op <= 1'b0;
        end else begin
            stg[0] <= flush ? '0 : stg_in;
            for (int j = 1; j < LATENCY; j++) begin
                stg[j] <= (flush && ((j - 1) < KILL_STAGES)) ? '0 : stg[j-1];
            end
            illegal_op <= in_valid && !legal && !flush;
        end
    end

    assign rt_wb        = stg[LATENCY-1].data;
    assign rt_addr_wb   = stg[LATENCY-1].addr;
    assign wb_valid     = stg[LATENCY-1].valid;
    assign reg_write_wb = stg[LATENCY-1].reg_write && stg[LATENCY-1].valid;

    always_comb begin
        stg_valid     = '0;
        stg_reg_write = '0;
        stg_addr      = '0;
        for (int j = 0; j < LATENCY; j++) begin
            stg_valid[j]     = stg[j].valid;
            stg_reg_write[j] = stg[j].reg_write;
            stg_addr[j]      = stg[j].addr;
        end
    end

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Bench for shift_rotate_pipe: default build and a LATENCY=5/KILL_STAGES=2 build
// share inputs; each has its own per-cycle expectation queue.
module tb_shift_rotate_pipe;

    typedef struct packed {
        logic         valid;
        logic         rw;
        logic [6:0]   addr;
        logic [127:0] data;
    } rec_t;

    typedef struct {
        logic [1:0]   op;
        logic [1:0]   esize;
        logic         use_imm;
        logic [127:0] ra;
        logic [127:0] rb;
        logic [6:0]   imm7;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, use_imm, reg_write, flush;
    logic [1:0]   op, esize;
    logic [127:0] ra, rb;
    logic [6:0]   imm7, rt_addr;

    logic [127:0]      rt3, rt5;
    logic [6:0]        ad3, ad5;
    logic              rw3, rw5, wv3, wv5, il3, il5;
    logic [2:0]        sv3, sr3;
    logic [2:0][6:0]   sa3;
    logic [4:0]        sv5, sr5;
    logic [4:0][6:0]   sa5;

    int   errors = 0;
    int   checks = 0;
    int   wb3_cnt = 0;
    int   wb5_cnt = 0;
    rec_t q3[$];
    rec_t q5[$];
    vec_t vt[13];

    always #5 clk = ~clk;

    shift_rotate_pipe dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .esize(esize),
        .use_imm(use_imm), .ra(ra), .rb(rb), .imm7(imm7), .rt_addr(rt_addr),
        .reg_write(reg_write), .flush(flush), .rt_wb(rt3), .rt_addr_wb(ad3),
        .reg_write_wb(rw3), .wb_valid(wv3), .stg_valid(sv3), .stg_reg_write(sr3),
        .stg_addr(sa3), .illegal_op(il3)
    );

    shift_rotate_pipe #(.LATENCY(5), .KILL_STAGES(2)) dut5 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .esize(esize),
        .use_imm(use_imm), .ra(ra), .rb(rb), .imm7(imm7), .rt_addr(rt_addr),
        .reg_write(reg_write), .flush(flush), .rt_wb(rt5), .rt_addr_wb(ad5),
        .reg_write_wb(rw5), .wb_valid(wv5), .stg_valid(sv5), .stg_reg_write(sr5),
        .stg_addr(sa5), .illegal_op(il5)
    );

    task automatic check(input string name, input logic [136:0] act, input logic [136:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rep16(input logic [15:0] h);
        return {8{h}};
    endfunction

    function automatic logic [127:0] rep32(input logic [31:0] w);
        return {4{w}};
    endfunction

    // Independent lane-by-lane reference using integer arithmetic.
    function automatic logic [127:0] ref_qw(input logic [1:0] o, input logic [1:0] es,
                                            input logic ui, input logic [127:0] a_qw,
                                            input logic [127:0] b_qw, input logic [6:0] im);
        logic [127:0] res;
        longint w, mask, a, c, n, r, s, pos;
        res = '0;
        if (es > 2'd1) return res;
        w    = (es == 2'd0) ? 16 : 32;
        mask = (longint'(1) << w) - 1;
        for (int k = 0; k < 128 / w; k++) begin
            pos = 128 - (k + 1) * w;
            a   = longint'(a_qw >> pos) & mask;
            c   = ui ? (longint'($signed(im)) & mask) : (longint'(b_qw >> pos) & mask);
            case (o)
                2'd0: begin n = c & (2*w - 1); r = (n < w) ? ((a << n) & mask) : 0; end
                2'd1: begin n = c & (w - 1); r = ((a << n) | (a >> (w - n))) & mask; end
                2'd2: begin n = (-c) & (2*w - 1); r = (n < w) ? (a >> n) : 0; end
                default: begin
                    n = (-c) & (2*w - 1);
                    s = (n < w) ? n : w - 1;
                    r = (a >> s) | (((a >> (w - 1)) != 0) ? (mask & ~(mask >> s)) : 0);
                end
            endcase
            res = res | (128'(r) << pos);
        end
        return res;
    endfunction

    task automatic prefill();
        q3.delete();
        q5.delete();
        repeat (2) q3.push_back('0);
        repeat (4) q5.push_back('0);
    endtask

    task automatic check_zero();
        check("rst3_wb", {wv3, rw3, ad3, rt3}, '0);
        check("rst3_stg", {109'b0, sv3, sr3, sa3, il3}, '0);
        check("rst5_wb", {wv5, rw5, ad5, rt5}, '0);
        check("rst5_stg", {91'b0, sv5, sr5, sa5, il5}, '0);
    endtask

    // Apply current inputs for one edge and check both builds after it.
    task automatic step(input logic [127:0] exp_data);
        rec_t            r, e;
        logic            ill;
        logic [2:0]      v3, w3;
        logic [2:0][6:0] a3;
        logic [4:0]      v5, w5;
        logic [4:0][6:0] a5;
        r = '0;
        if (in_valid && esize < 2'd2 && !flush) begin
            r.valid = 1'b1;
            r.rw    = reg_write;
            r.addr  = rt_addr;
            r.data  = exp_data;
        end
        if (flush) begin
            q3[q3.size() - 1] = '0;
            q5[q5.size() - 1] = '0;
            q5[q5.size() - 2] = '0;
        end
        q3.push_back(r);
        q5.push_back(r);
        ill = in_valid && (esize >= 2'd2) && !flush;
        @(posedge clk);
        #1;
        if (wv3) wb3_cnt++;
        if (wv5) wb5_cnt++;

        e = q3.pop_front();
        check("wb3", {wv3, rw3, ad3, rt3}, e);
        v3[2] = e.valid; w3[2] = e.rw; a3[2] = e.addr;
        for (int j = 0; j < 2; j++) begin
            v3[j] = q3[q3.size() - 1 - j].valid;
            w3[j] = q3[q3.size() - 1 - j].rw;
            a3[j] = q3[q3.size() - 1 - j].addr;
        end
        check("stg3", {110'b0, sv3, sr3, sa3}, {110'b0, v3, w3, a3});
        check("ill3", {136'b0, il3}, {136'b0, ill});

        e = q5.pop_front();
        check("wb5", {wv5, rw5, ad5, rt5}, e);
        v5[4] = e.valid; w5[4] = e.rw; a5[4] = e.addr;
        for (int j = 0; j < 4; j++) begin
            v5[j] = q5[q5.size() - 1 - j].valid;
            w5[j] = q5[q5.size() - 1 - j].rw;
            a5[j] = q5[q5.size() - 1 - j].addr;
        end
        check("stg5", {92'b0, sv5, sr5, sa5}, {92'b0, v5, w5, a5});
        check("ill5", {136'b0, il5}, {136'b0, ill});
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; flush = 1'b0; esize = 2'd0;
        repeat (n) step('0);
    endtask

    task automatic load(input vec_t v, input logic [6:0] addr);
        in_valid = 1'b1; flush = 1'b0; reg_write = 1'b1; rt_addr = addr;
        op = v.op; esize = v.esize; use_imm = v.use_imm;
        ra = v.ra; rb = v.rb; imm7 = v.imm7;
    endtask

    initial begin
        vt[0]  = '{2'd0, 2'd0, 1'b0, rep16(16'h8001), rep16(16'h0001), 7'h00, rep16(16'h0002)};
        vt[1]  = '{2'd1, 2'd1, 1'b1, rep32(32'h80000001), '0, 7'h7F, rep32(32'hC0000000)};
        vt[2]  = '{2'd3, 2'd0, 1'b0, rep16(16'h8000), rep16(16'hFFF0), 7'h00, rep16(16'hFFFF)};
        vt[3]  = '{2'd2, 2'd0, 1'b0, rep16(16'h8000), rep16(16'hFFF0), 7'h00, rep16(16'h0000)};
        vt[4]  = '{2'd0, 2'd0, 1'b0, rep16(16'hFFFF), rep16(16'h0010), 7'h00, rep16(16'h0000)};
        vt[5]  = '{2'd0, 2'd1, 1'b0, rep32(32'h12345678), rep32(32'h00000004), 7'h00, rep32(32'h23456780)};
        vt[6]  = '{2'd1, 2'd0, 1'b0, rep16(16'h1234), rep16(16'h0004), 7'h00, rep16(16'h2341)};
        vt[7]  = '{2'd2, 2'd1, 1'b0, rep32(32'h80000000), rep32(32'hFFFFFFFC), 7'h00, rep32(32'h08000000)};
        vt[8]  = '{2'd3, 2'd1, 1'b1, rep32(32'h80000000), '0, 7'h78, rep32(32'hFF800000)};
        vt[9]  = '{2'd0, 2'd0, 1'b0, rep16(16'h0001),
                   128'h0000_0001_0002_0003_0004_0005_0006_0007, 7'h00,
                   128'h0001_0002_0004_0008_0010_0020_0040_0080};
        vt[10] = '{2'd1, 2'd0, 1'b0, rep16(16'h8001), rep16(16'h0011), 7'h00, rep16(16'h0003)};
        vt[11] = '{2'd0, 2'd0, 1'b1, rep16(16'h1234), '0, 7'h3F, rep16(16'h0000)};
        vt[12] = '{2'd3, 2'd0, 1'b0, rep16(16'h7FFF), rep16(16'hFFF0), 7'h00, rep16(16'h0000)};

        reset = 1'b0; in_valid = 1'b0; flush = 1'b0; reg_write = 1'b0; use_imm = 1'b0;
        op = 2'd0; esize = 2'd0; ra = '0; rb = '0; imm7 = '0; rt_addr = '0;
        #1 reset = 1'b1;
        #1 check_zero();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        prefill();

        // Directed vectors, back to back.
        for (int i = 0; i < 13; i++) begin
            load(vt[i], 7'(i + 1));
            step(vt[i].exp);
        end
        idle(5);

        // A, B, C with flush on C: default build retires only A, deep build none.
        wb3_cnt = 0; wb5_cnt = 0;
        load(vt[0], 7'h11); step(vt[0].exp);
        load(vt[5], 7'h12); step(vt[5].exp);
        load(vt[6], 7'h13); flush = 1'b1; step(vt[6].exp);
        idle(6);
        check("flush_retired3", 137'(wb3_cnt), 137'(1));
        check("flush_retired5", 137'(wb5_cnt), 137'(0));

        // Illegal size: pulse, then suppressed by same-edge flush.
        load(vt[0], 7'h21); esize = 2'd3; step('0);
        load(vt[0], 7'h22); esize = 2'd2; flush = 1'b1; step('0);
        idle(5);

        // Reset mid-flight, then the first op after reset.
        load(vt[1], 7'h31); step(vt[1].exp);
        load(vt[2], 7'h32); step(vt[2].exp);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_zero();
        @(posedge clk);
        #1 reset = 1'b0;
        prefill();
        load(vt[9], 7'h33); step(vt[9].exp);
        idle(5);

        // Random continuous issue against the reference model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 8);
            flush     = ($urandom_range(0, 9) == 0);
            op        = 2'($urandom_range(0, 3));
            esize     = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            use_imm   = 1'($urandom_range(0, 1));
            reg_write = 1'($urandom_range(0, 1));
            rt_addr   = 7'($urandom);
            imm7      = 7'($urandom);
            ra        = {$urandom, $urandom, $urandom, $urandom};
            rb        = {$urandom, $urandom, $urandom, $urandom};
            step(ref_qw(op, esize, use_imm, ra, rb, imm7));
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
